// File: rtl/keycode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keycode_pkg
// Description : Default HID key bindings, jump state encoding, slot matcher.
// Revision    : 1.0 - initial release
// ============================================================================
package keycode_pkg;

    localparam logic [7:0] c_hid_a     = 8'h04;
    localparam logic [7:0] c_hid_d     = 8'h07;
    localparam logic [7:0] c_hid_s     = 8'h16;
    localparam logic [7:0] c_hid_w     = 8'h1A;
    localparam logic [7:0] c_hid_space = 8'h2C;
    localparam logic [7:0] c_hid_none  = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASCEND  = 2'd1,
        LOCKOUT = 2'd2
    } jump_state_t;

    // A key is held if either slot carries it; the empty code never matches.
    function automatic logic key_held(input logic [15:0] word, input logic [7:0] code);
        return (code != c_hid_none) && ((word[7:0] == code) || (word[15:8] == code));
    endfunction

endpackage
`default_nettype wire

// File: rtl/keycode_action_decoder_key_repeat_timer.sv
`default_nettype none
// ============================================================================
// Module      : key_repeat_timer
// Description : Frame-rate press-edge pulse with auto-repeat while held.
// Revision    : 1.0 - initial release
// ============================================================================
module key_repeat_timer #(
    parameter int REPEAT_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_held,
    output logic o_pulse
);

    localparam logic [7:0] c_reload = 8'(REPEAT_FRAMES);

    logic       r_prev;
    logic [7:0] r_cnt;
    logic       r_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_cnt   <= 8'd0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (i_tick) begin
                r_prev <= i_held;
                if (i_held && !r_prev) begin
                    r_pulse <= 1'b1;
                    r_cnt   <= c_reload;
                end else if (i_held) begin
                    // Count reaching 1 marks the end of one repeat interval.
                    if (r_cnt == 8'd1) begin
                        r_pulse <= 1'b1;
                        r_cnt   <= c_reload;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end else begin
                    r_cnt <= 8'd0;
                end
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/keycode_action_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keycode_action_decoder
// Description : Turns the two-slot HID keycode word into per-frame game controls.
// Revision    : 1.0 - initial release
// ============================================================================
module keycode_action_decoder
    import keycode_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT        = c_hid_a,
    parameter logic [7:0] KEY_RIGHT       = c_hid_d,
    parameter logic [7:0] KEY_CROUCH      = c_hid_s,
    parameter logic [7:0] KEY_JUMP        = c_hid_w,
    parameter logic [7:0] KEY_SHOOT       = c_hid_space,
    parameter int         JUMP_MAX_FRAMES = 16,
    parameter int         REPEAT_FRAMES   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] keycode,
    input  logic        frame_tick,
    output logic        move_left,
    output logic        move_right,
    output logic        crouch,
    output logic        jump_start,
    output logic        jump_active,
    output logic        shoot
);

    localparam logic [7:0] c_jump_max = 8'(JUMP_MAX_FRAMES);

    logic [15:0] r_key_q;
    logic        r_move_left;
    logic        r_move_right;
    logic        r_crouch;
    logic        r_jump_start;
    jump_state_t r_state;
    jump_state_t w_state_nxt;
    logic [7:0]  r_jcnt;
    logic [7:0]  w_jcnt_nxt;
    logic        w_jump_start_nxt;

    logic w_held_left, w_held_right, w_held_crouch, w_held_jump, w_held_shoot;

    assign w_held_left   = key_held(r_key_q, KEY_LEFT);
    assign w_held_right  = key_held(r_key_q, KEY_RIGHT);
    assign w_held_crouch = key_held(r_key_q, KEY_CROUCH);
    assign w_held_jump   = key_held(r_key_q, KEY_JUMP);
    assign w_held_shoot  = key_held(r_key_q, KEY_SHOOT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_q      <= 16'd0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_crouch     <= 1'b0;
        end else begin
            r_key_q <= keycode;
            if (frame_tick) begin
                r_move_left  <= w_held_left && !w_held_right;
                r_move_right <= w_held_right && !w_held_left;
                r_crouch     <= w_held_crouch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_jcnt       <= 8'd0;
            r_jump_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_jcnt       <= w_jcnt_nxt;
            r_jump_start <= w_jump_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_jcnt_nxt       = r_jcnt;
        w_jump_start_nxt = 1'b0;
        if (frame_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_held_jump) begin
                        w_state_nxt      = ASCEND;
                        w_jcnt_nxt       = 8'd1;
                        w_jump_start_nxt = 1'b1;
                    end
                end
                ASCEND: begin
                    if (!w_held_jump) begin
                        w_state_nxt = IDLE;
                        w_jcnt_nxt  = 8'd0;
                    end else if (r_jcnt == c_jump_max) begin
                        w_state_nxt = LOCKOUT;
                    end else begin
                        w_jcnt_nxt = r_jcnt + 8'd1;
                    end
                end
                LOCKOUT: begin
                    // Only a release re-arms the jump.
                    if (!w_held_jump) begin
                        w_state_nxt = IDLE;
                        w_jcnt_nxt  = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_jcnt_nxt  = 8'd0;
                end
            endcase
        end
    end

    key_repeat_timer #(
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) u_shoot_timer (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (frame_tick),
        .i_held  (w_held_shoot),
        .o_pulse (shoot)
    );

    assign move_left   = r_move_left;
    assign move_right  = r_move_right;
    assign crouch      = r_crouch;
    assign jump_start  = r_jump_start;
    assign jump_active = (r_state == ASCEND);

endmodule
`default_nettype wire

// File: tb/tb_keycode_action_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keycode_action_decoder
// Description : Self-checking bench for keycode_action_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keycode_action_decoder;

    localparam int c_jmax = 16;
    localparam int c_rep  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keycode;
    logic        frame_tick;
    logic        move_left, move_right, crouch, jump_start, jump_active, shoot;

    int n_checks = 0;
    int n_errors = 0;
    int n_js, n_sh, n_ja;

    // Reference state: tick-held counts per key rather than FSM states.
    logic [15:0] m_kq;
    int          m_jn, m_sn;
    logic        e_ml, e_mr, e_cr, e_js, e_ja, e_sh;

    keycode_action_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .keycode     (keycode),
        .frame_tick  (frame_tick),
        .move_left   (move_left),
        .move_right  (move_right),
        .crouch      (crouch),
        .jump_start  (jump_start),
        .jump_active (jump_active),
        .shoot       (shoot)
    );

    always #5 clk = ~clk;

    function automatic logic m_held(input logic [15:0] w, input logic [7:0] k);
        logic [7:0] lo, hi;
        lo = w[7:0];
        hi = w[15:8];
        return (lo == k) || (hi == k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_kq = 16'd0;
            m_jn = 0;
            m_sn = 0;
            {e_ml, e_mr, e_cr, e_js, e_ja, e_sh} = 6'd0;
        end else begin
            e_js = 1'b0;
            e_sh = 1'b0;
            if (frame_tick) begin
                e_ml = m_held(m_kq, 8'h04) && !m_held(m_kq, 8'h07);
                e_mr = m_held(m_kq, 8'h07) && !m_held(m_kq, 8'h04);
                e_cr = m_held(m_kq, 8'h16);
                m_jn = m_held(m_kq, 8'h1A) ? m_jn + 1 : 0;
                e_js = (m_jn == 1);
                e_ja = (m_jn >= 1) && (m_jn <= c_jmax);
                m_sn = m_held(m_kq, 8'h2C) ? m_sn + 1 : 0;
                e_sh = (m_sn >= 1) && (((m_sn - 1) % c_rep) == 0);
            end
            m_kq = keycode;
        end
    end

    always @(negedge clk) begin
        check("move_left",   move_left,   e_ml);
        check("move_right",  move_right,  e_mr);
        check("crouch",      crouch,      e_cr);
        check("jump_start",  jump_start,  e_js);
        check("jump_active", jump_active, e_ja);
        check("shoot",       shoot,       e_sh);
    end

    task automatic tick(input int gap);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        n_js += int'(jump_start);
        n_sh += int'(shoot);
        n_ja += int'(jump_active);
        repeat (gap) @(negedge clk);
    endtask

    task automatic clr();
        n_js = 0;
        n_sh = 0;
        n_ja = 0;
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h04;
            2: return 8'h07;
            3: return 8'h16;
            4: return 8'h1A;
            5: return 8'h2C;
            6: return 8'($urandom_range(0, 255));
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        reset      = 1'b1;
        keycode    = 16'h0407;
        frame_tick = 1'b0;
        clr();
        repeat (2) @(negedge clk);
        tick(1);
        tick(1);
        check("rst_outputs", {move_left, move_right, crouch, jump_start, jump_active, shoot}, 0);
        reset = 1'b0;
        tick(1);
        check("cancel_left", move_left, 0);
        check("cancel_right", move_right, 0);

        keycode = 16'h0004;
        tick(1);
        check("left_held", move_left, 1);
        keycode = 16'h0700;
        tick(1);
        check("right_left", move_left, 0);
        check("right_held", move_right, 1);
        keycode = 16'h0000;
        tick(1);

        clr();
        keycode = 16'h001A;
        repeat (20) tick(2);
        check("jump20_starts", n_js, 1);
        check("jump20_active", n_ja, 16);
        check("jump20_locked", jump_active, 0);
        keycode = 16'h0000;
        tick(1);
        clr();
        keycode = 16'h001A;
        tick(1);
        check("jump_repress", n_js, 1);
        keycode = 16'h0000;
        tick(1);
        tick(1);

        clr();
        keycode = 16'h001A;
        repeat (5) tick(1);
        keycode = 16'h0000;
        tick(1);
        check("jump_release_fall", jump_active, 0);
        keycode = 16'h001A;
        tick(1);
        check("jump_rerun_starts", n_js, 2);
        check("jump_rerun_active", n_ja, 6);
        keycode = 16'h0000;
        tick(1);
        tick(1);

        clr();
        keycode = 16'h2C00;
        repeat (17) tick(3);
        check("shoot17_pulses", n_sh, 3);
        keycode = 16'h0000;
        tick(1);

        clr();
        keycode = 16'h2C1A;
        tick(1);
        check("combo_js", n_js, 1);
        check("combo_sh", n_sh, 1);
        tick(1);
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {move_left, move_right, crouch, jump_start, jump_active, shoot}, 0);
        reset = 1'b0;
        clr();
        tick(1);
        check("postrst_js", n_js, 1);
        check("postrst_sh", n_sh, 1);

        repeat (6000) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) keycode = {pick(), pick()};
            frame_tick = ($urandom_range(0, 2) == 0);
            reset      = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
